sp_ram_pipe: RTL and testbench

//  Parametrised single-port synchronous RAM with a one-op-per-cycle cs/ready handshake.

---
 rtl/sp_ram_pipe.sv | 184 ++++++++++++++++++
 tb/tb_sp_ram_pipe.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_pipe.sv
// Single-port synchronous RAM with byte enables, 1- or 2-cycle pipelined reads,
// selectable write-return data and an optional post-reset zeroing engine.
module sp_ram_pipe #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 10,
    parameter int DEPTH      = 1024,
    parameter int RD_LAT     = 1,
    parameter int WR_MODE    = 0,
    parameter int CLR_ON_RST = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cs,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic                ready,
    output logic                busy,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid
);
    // Handshake: an access is taken on every edge where cs && ready; the return
    // path (rvalid/rdata) has no backpressure and is a single-cycle pulse.

    localparam int NB = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  clr_addr_q, clr_addr_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_q;

    logic              accept;
    logic              in_range;
    logic              ret_en;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [NB-1:0]     wr_be;

    logic              v1_q, v1_d;
    logic              zero1_q, zero1_d;
    logic              mrg1_q, mrg1_d;
    logic [DATA_W-1:0] wd1_q, wd1_d;
    logic [NB-1:0]     be1_q, be1_d;
    logic [DATA_W-1:0] word1;

    assign ready    = (state_q == ST_IDLE);
    assign busy     = (state_q == ST_CLEAR);
    assign accept   = cs && ready;
    assign in_range = ({1'b0, addr} < DEPTH_X);
    assign ret_en   = accept && (!we || (WR_MODE != 0));

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == ST_CLEAR) begin
            clr_addr_d = clr_addr_q + IDX_W'(1);
            if (clr_addr_q == LAST_IDX) begin
                state_d    = ST_IDLE;
                clr_addr_d = '0;
            end
        end
    end

    // The clear engine owns the write port while busy; host writes use it otherwise.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = addr[IDX_W-1:0];
        wr_data = wdata;
        wr_be   = be;
        if (state_q == ST_CLEAR) begin
            wr_en   = 1'b1;
            wr_idx  = clr_addr_q;
            wr_data = '0;
            wr_be   = '1;
        end else if (accept && we && in_range) begin
            wr_en = 1'b1;
        end
        if (!rst_n) begin
            wr_en = 1'b0;
        end
    end

    always_comb begin
        v1_d    = ret_en;
        zero1_d = zero1_q;
        mrg1_d  = mrg1_q;
        wd1_d   = wd1_q;
        be1_d   = be1_q;
        if (ret_en) begin
            zero1_d = !in_range;
            mrg1_d  = we && (WR_MODE == 1);
            wd1_d   = wdata;
            be1_d   = be;
        end
    end

    // Write-first return merges the new lanes onto the old word from the read register.
    always_comb begin
        word1 = ram_q;
        for (int i = 0; i < NB; i++) begin
            if (mrg1_q && be1_q[i]) begin
                word1[8*i +: 8] = wd1_q[8*i +: 8];
            end
        end
        if (zero1_q) begin
            word1 = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
            clr_addr_q <= '0;
            v1_q       <= 1'b0;
            zero1_q    <= 1'b1;
            mrg1_q     <= 1'b0;
            wd1_q      <= '0;
            be1_q      <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            v1_q       <= v1_d;
            zero1_q    <= zero1_d;
            mrg1_q     <= mrg1_d;
            wd1_q      <= wd1_d;
            be1_q      <= be1_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_en && wr_be[i]) begin
                mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
        if (ret_en) begin
            ram_q <= mem[addr[IDX_W-1:0]];
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              v2_q, v2_d;
            logic [DATA_W-1:0] out2_q, out2_d;

            always_comb begin
                v2_d   = v1_q;
                out2_d = out2_q;
                if (v1_q) begin
                    out2_d = word1;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    v2_q   <= 1'b0;
                    out2_q <= '0;
                end else begin
                    v2_q   <= v2_d;
                    out2_q <= out2_d;
                end
            end

            assign rvalid = v2_q;
            assign rdata  = out2_q;
        end else begin : g_lat1
            assign rvalid = v1_q;
            assign rdata  = word1;
        end
    endgenerate

endmodule

// File: tb/tb_sp_ram_pipe.sv
// Directed bench for sp_ram_pipe: three configurations share one clock and input bus,
// each selected by its own cs and reset.
module tb_sp_ram_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, rst_c;
  logic        cs_a, cs_b, cs_c;
  logic        we;
  logic [3:0]  be;
  logic [4:0]  addr;
  logic [31:0] wdata;

  logic        ready_a, busy_a, rvalid_a;
  logic [7:0]  rdata_a;
  logic        ready_b, busy_b, rvalid_b;
  logic [31:0] rdata_b;
  logic        ready_c, busy_c, rvalid_c;
  logic [7:0]  rdata_c;

  // a: 8-bit, 16 words behind a 5-bit address, RD_LAT=1, read-first return, cleared
  sp_ram_pipe #(.DATA_W(8), .ADDR_W(5), .DEPTH(16), .RD_LAT(1), .WR_MODE(2), .CLR_ON_RST(1)) u_a (
    .clk(clk), .rst_n(rst_a), .cs(cs_a), .we(we), .be(be[0:0]), .addr(addr),
    .wdata(wdata[7:0]), .ready(ready_a), .busy(busy_a), .rdata(rdata_a), .rvalid(rvalid_a));

  // b: 32-bit, RD_LAT=1, write-first return, cleared
  sp_ram_pipe #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .RD_LAT(1), .WR_MODE(1), .CLR_ON_RST(1)) u_b (
    .clk(clk), .rst_n(rst_b), .cs(cs_b), .we(we), .be(be), .addr(addr[3:0]),
    .wdata(wdata), .ready(ready_b), .busy(busy_b), .rdata(rdata_b), .rvalid(rvalid_b));

  // c: 8-bit, RD_LAT=2, no write return, contents kept across reset
  sp_ram_pipe #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .RD_LAT(2), .WR_MODE(0), .CLR_ON_RST(0)) u_c (
    .clk(clk), .rst_n(rst_c), .cs(cs_c), .we(we), .be(be[0:0]), .addr(addr[3:0]),
    .wdata(wdata[7:0]), .ready(ready_c), .busy(busy_c), .rdata(rdata_c), .rvalid(rvalid_c));

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          w;
    logic        cs;
    logic        we;
    logic [3:0]  be;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        ev;
    logic [31:0] ed;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic get_rv(input int w);
    case (w)
      0:       return rvalid_a;
      1:       return rvalid_b;
      default: return rvalid_c;
    endcase
  endfunction

  function automatic logic [31:0] get_rd(input int w);
    case (w)
      0:       return {24'b0, rdata_a};
      1:       return rdata_b;
      default: return {24'b0, rdata_c};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w, input logic c, input logic w_e, input logic [3:0] b,
                       input logic [4:0] a, input logic [31:0] d);
    cs_a  = (w == 0) && c;
    cs_b  = (w == 1) && c;
    cs_c  = (w == 2) && c;
    we    = w_e;
    be    = b;
    addr  = a;
    wdata = d;
  endtask

  task automatic idle();
    drive(0, 1'b0, 1'b0, 4'h0, 5'd0, 32'h0);
  endtask

  task automatic add(input int w, input logic c, input logic w_e, input logic [3:0] b,
                     input logic [4:0] a, input logic [31:0] d, input logic ev, input logic [31:0] ed);
    vec_t v;
    v.w = w; v.cs = c; v.we = w_e; v.be = b; v.addr = a; v.wdata = d; v.ev = ev; v.ed = ed;
    vt.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;

    // reset all three
    idle();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    tick();
    check("rst_a_ready", {31'b0, ready_a}, 32'd0);
    check("rst_a_busy", {31'b0, busy_a}, 32'd1);
    check("rst_a_rvalid", {31'b0, rvalid_a}, 32'd0);
    check("rst_a_rdata", get_rd(0), 32'h0);
    check("rst_b_rdata", get_rd(1), 32'h0);
    check("rst_c_ready", {31'b0, ready_c}, 32'd1);
    check("rst_c_busy", {31'b0, busy_c}, 32'd0);
    check("rst_c_rvalid", {31'b0, rvalid_c}, 32'd0);
    check("rst_c_rdata", get_rd(2), 32'h0);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

    // clear engine: ready after exactly DEPTH edges
    n = 0;
    while (!ready_a && n < 100) begin
      check("clr_busy_a", {31'b0, busy_a}, 32'd1);
      check("clr_rvalid_a", {31'b0, rvalid_a}, 32'd0);
      tick();
      n++;
    end
    check("clr_cycles_a", n, 32'd16);
    check("clr_ready_b", {31'b0, ready_b}, 32'd1);

    // table: single-cycle-latency instances a and b
    for (int i = 0; i < 16; i++) add(0, 1, 0, 4'h0, 5'(i), 32'h0, 1, 32'h0);
    add(1, 1, 0, 4'h0, 5'd7, 32'h0, 1, 32'h0);
    add(1, 1, 1, 4'hF, 5'd5, 32'hAABBCCDD, 1, 32'hAABBCCDD);
    add(1, 1, 1, 4'h5, 5'd5, 32'h11223344, 1, 32'hAA22CC44);
    add(1, 1, 0, 4'h0, 5'd5, 32'h0, 1, 32'hAA22CC44);
    add(1, 1, 1, 4'h1, 5'd3, 32'h0000005A, 1, 32'h0000005A);
    add(1, 1, 1, 4'h1, 5'd3, 32'h000000A5, 1, 32'h000000A5);
    add(0, 1, 1, 4'h1, 5'd3, 32'h5A, 1, 32'h00);
    add(0, 1, 1, 4'h1, 5'd3, 32'hA5, 1, 32'h5A);
    add(0, 1, 0, 4'h0, 5'd3, 32'h0, 1, 32'hA5);
    add(0, 0, 0, 4'h0, 5'd0, 32'h0, 0, 32'h0);
    add(0, 1, 1, 4'h1, 5'd19, 32'h77, 1, 32'h00);
    add(0, 1, 0, 4'h0, 5'd19, 32'h0, 1, 32'h00);
    add(0, 1, 0, 4'h0, 5'd3, 32'h0, 1, 32'hA5);
    add(0, 1, 1, 4'h0, 5'd3, 32'hFF, 1, 32'hA5);
    add(0, 1, 0, 4'h0, 5'd3, 32'h0, 1, 32'hA5);
    add(0, 1, 1, 4'h1, 5'd12, 32'h99, 1, 32'h00);
    add(0, 1, 0, 4'h0, 5'd12, 32'h0, 1, 32'h99);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].w, vt[i].cs, vt[i].we, vt[i].be, vt[i].addr, vt[i].wdata);
      tick();
      check($sformatf("vec%0d_rvalid", i), {31'b0, get_rv(vt[i].w)}, {31'b0, vt[i].ev});
      if (vt[i].ev) check($sformatf("vec%0d_rdata", i), get_rd(vt[i].w), vt[i].ed);
    end
    idle();
    tick();
    check("hold_rdata_a", get_rd(0), 32'h99);
    check("hold_rvalid_a", {31'b0, rvalid_a}, 32'd0);

    // RD_LAT=2: fill 0..7, then 8 back-to-back reads
    for (int i = 0; i < 8; i++) begin
      drive(2, 1, 1, 4'h1, 5'(i), 32'h10 + 32'(i));
      tick();
      check($sformatf("fill%0d_rvalid_c", i), {31'b0, rvalid_c}, 32'd0);
    end
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(2, 1, 0, 4'h0, 5'(i), 32'h0);
      else idle();
      tick();
      check($sformatf("b2b%0d_rvalid_c", i), {31'b0, rvalid_c}, {31'b0, (i >= 1 && i <= 8)});
      if (i >= 1 && i <= 8) check($sformatf("b2b%0d_rdata_c", i), get_rd(2), 32'h10 + 32'(i - 1));
    end

    // WR_MODE=0: write produces no return
    drive(2, 1, 1, 4'h1, 5'd3, 32'hA5);
    tick();
    check("wr0_rvalid_c_1", {31'b0, rvalid_c}, 32'd0);
    idle();
    tick();
    check("wr0_rvalid_c_2", {31'b0, rvalid_c}, 32'd0);
    tick();
    check("wr0_rvalid_c_3", {31'b0, rvalid_c}, 32'd0);

    // reset during clear at clr_addr=7, with a write attempt held through the clear
    rst_a = 1'b0;
    tick();
    rst_a = 1'b1;
    repeat (7) tick();
    rst_a = 1'b0;
    tick();
    check("midclr_busy_a", {31'b0, busy_a}, 32'd1);
    check("midclr_ready_a", {31'b0, ready_a}, 32'd0);
    check("midclr_rdata_a", get_rd(0), 32'h0);
    rst_a = 1'b1;
    n = 0;
    while (!ready_a && n < 100) begin
      drive(0, 1, 1, 4'h1, 5'd12, 32'h66);
      check("clr2_rvalid_a", {31'b0, rvalid_a}, 32'd0);
      tick();
      n++;
    end
    check("clr2_cycles_a", n, 32'd16);
    drive(0, 1, 0, 4'h0, 5'd12, 32'h0);
    tick();
    check("clr2_rvalid12_a", {31'b0, rvalid_a}, 32'd1);
    check("clr2_rdata12_a", get_rd(0), 32'h0);
    drive(0, 1, 0, 4'h0, 5'd3, 32'h0);
    tick();
    check("clr2_rdata3_a", get_rd(0), 32'h0);
    idle();

    // CLR_ON_RST=0: reset right after a read accept drops it, contents survive
    drive(2, 1, 1, 4'h1, 5'd9, 32'h3C);
    tick();
    drive(2, 1, 0, 4'h0, 5'd9, 32'h0);
    tick();
    check("r6_accept_rvalid_c", {31'b0, rvalid_c}, 32'd0);
    idle();
    rst_c = 1'b0;
    tick();
    check("r6_rst_rvalid_c", {31'b0, rvalid_c}, 32'd0);
    check("r6_rst_rdata_c", get_rd(2), 32'h0);
    rst_c = 1'b1;
    tick();
    check("r6_post1_rvalid_c", {31'b0, rvalid_c}, 32'd0);
    tick();
    check("r6_post2_rvalid_c", {31'b0, rvalid_c}, 32'd0);
    check("r6_ready_c", {31'b0, ready_c}, 32'd1);
    drive(2, 1, 0, 4'h0, 5'd9, 32'h0);
    tick();
    check("r6_lat1_rvalid_c", {31'b0, rvalid_c}, 32'd0);
    idle();
    tick();
    check("r6_lat2_rvalid_c", {31'b0, rvalid_c}, 32'd1);
    check("r6_rdata_c", get_rd(2), 32'h3C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
